// File: rtl/decode_pkg.sv
// Shared encodings for the instruction-decode stage: opcodes, functs,
// ALU operations, PC-source selects and the ID/EX register layout.
package decode_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] PCSRC_BRANCH = 2'b00;
    localparam logic [1:0] PCSRC_JR     = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;
    localparam logic [1:0] PCSRC_EXC    = 2'b11;

    typedef struct packed {
        logic [2:0]  aluop;
        logic        alusrc;
        logic [31:0] rega;
        logic [31:0] regb;
        logic [31:0] imedext;
        logic [4:0]  regdest;
        logic        memread;
        logic        memwrite;
        logic        regwrite;
        logic        memtoreg;
    } idex_t;

    function automatic logic [2:0] alu_from_funct(input logic [5:0] funct);
        logic [2:0] op;
        op = ALU_ADD;
        case (funct)
            FN_SUB:  op = ALU_SUB;
            FN_AND:  op = ALU_AND;
            FN_OR:   op = ALU_OR;
            FN_SLT:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] sign_ext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_reg_bank.sv
// 32x32 register bank: two asynchronous reads, one clocked write, r0 hard-wired
// to zero, and a write-through path so a same-cycle WB write is visible to reads.
module reg_bank
    import decode_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic [4:0]  raddr_a_i,
    input  logic [4:0]  raddr_b_i,
    output logic [31:0] rdata_a_o,
    output logic [31:0] rdata_b_o,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [31:0] wdata_i
);

    logic [31:0] regs_q [0:31];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != 5'd0)) begin
            regs_q[waddr_i] <= wdata_i;
        end
    end

    function automatic logic [31:0] read_port(input logic [4:0] addr,
                                              input logic [31:0] stored);
        logic [31:0] v;
        v = stored;
        if (addr == 5'd0) begin
            v = '0;
        end else if (we_i && (waddr_i == addr)) begin
            v = wdata_i;
        end
        return v;
    endfunction

    assign rdata_a_o = read_port(raddr_a_i, regs_q[raddr_a_i]);
    assign rdata_b_o = read_port(raddr_b_i, regs_q[raddr_b_i]);

endmodule

// File: rtl/decode.sv
// Instruction-decode stage: register read, branch/jump resolution with one
// delay slot, load-use/RAW stall detection and the ID/EX pipeline register.
module decode
    import decode_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'h0000_0040
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] if_id_nextpc,
    input  logic [31:0] if_id_instruc,
    output logic        id_stall,
    output logic        id_if_selpcsource,
    output logic [1:0]  id_if_selpctype,
    output logic [31:0] id_if_pcimd2ext,
    output logic [31:0] id_if_rega,
    output logic [31:0] id_if_pcindex,
    input  logic        ex_id_regwrite,
    input  logic [4:0]  ex_id_dest,
    input  logic        mem_id_regwrite,
    input  logic [4:0]  mem_id_dest,
    input  logic        wb_id_we,
    input  logic [4:0]  wb_id_dest,
    input  logic [31:0] wb_id_data,
    output logic [2:0]  id_ex_aluop,
    output logic        id_ex_alusrc,
    output logic [31:0] id_ex_rega,
    output logic [31:0] id_ex_regb,
    output logic [31:0] id_ex_imedext,
    output logic [4:0]  id_ex_regdest,
    output logic        id_ex_memread,
    output logic        id_ex_memwrite,
    output logic        id_ex_regwrite,
    output logic        id_ex_memtoreg
);

    // Fetch builds the exception target itself; a misaligned vector is unusable.
    if (EXC_VECTOR[1:0] != 2'b00) begin : g_bad_exc_vector
        $error("EXC_VECTOR must be word aligned");
    end

    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [31:0] imm_ext;
    logic [31:0] rs_val;
    logic [31:0] rt_val;

    assign opcode  = if_id_instruc[31:26];
    assign rs      = if_id_instruc[25:21];
    assign rt      = if_id_instruc[20:16];
    assign rd      = if_id_instruc[15:11];
    assign funct   = if_id_instruc[5:0];
    assign imm_ext = sign_ext16(if_id_instruc[15:0]);

    reg_bank u_reg_bank (
        .clock     (clock),
        .reset     (reset),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rs_val),
        .rdata_b_o (rt_val),
        .we_i      (wb_id_we),
        .waddr_i   (wb_id_dest),
        .wdata_i   (wb_id_data)
    );

    logic        uses_rs;
    logic        uses_rt;
    logic        issue;
    logic        redirect;
    logic [1:0]  pctype;
    idex_t       dec;

    // Control-transfer instructions complete here, so they carry nothing into EX.
    always_comb begin
        uses_rs     = 1'b0;
        uses_rt     = 1'b0;
        issue       = 1'b0;
        redirect    = 1'b0;
        pctype      = PCSRC_BRANCH;
        dec         = '0;
        dec.aluop   = ALU_ADD;
        dec.rega    = rs_val;
        dec.regb    = rt_val;
        dec.imedext = imm_ext;
        case (opcode)
            OP_RTYPE: begin
                if (if_id_instruc != 32'd0) begin
                    uses_rs = 1'b1;
                    uses_rt = 1'b1;
                    case (funct)
                        FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: begin
                            issue        = 1'b1;
                            dec.aluop    = alu_from_funct(funct);
                            dec.regdest  = rd;
                            dec.regwrite = 1'b1;
                        end
                        FN_JR: begin
                            redirect = 1'b1;
                            pctype   = PCSRC_JR;
                        end
                        default: begin
                            redirect = 1'b1;
                            pctype   = PCSRC_EXC;
                        end
                    endcase
                end
            end
            OP_ADDI: begin
                uses_rs      = 1'b1;
                issue        = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regdest  = rt;
                dec.regwrite = 1'b1;
            end
            OP_LW: begin
                uses_rs      = 1'b1;
                issue        = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regdest  = rt;
                dec.memread  = 1'b1;
                dec.regwrite = 1'b1;
                dec.memtoreg = 1'b1;
            end
            OP_SW: begin
                uses_rs      = 1'b1;
                uses_rt      = 1'b1;
                issue        = 1'b1;
                dec.alusrc   = 1'b1;
                dec.memwrite = 1'b1;
            end
            OP_BEQ: begin
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
                redirect = (rs_val == rt_val);
            end
            OP_BNE: begin
                uses_rs  = 1'b1;
                uses_rt  = 1'b1;
                redirect = (rs_val != rt_val);
            end
            OP_J: begin
                redirect = 1'b1;
                pctype   = PCSRC_JUMP;
            end
            default: begin
                uses_rs  = 1'b1;
                redirect = 1'b1;
                pctype   = PCSRC_EXC;
            end
        endcase
    end

    function automatic logic pending_write(input logic [4:0] src);
        return (src != 5'd0) &&
               ((ex_id_regwrite  && (ex_id_dest  == src)) ||
                (mem_id_regwrite && (mem_id_dest == src)));
    endfunction

    logic hazard;
    assign hazard = (uses_rs && pending_write(rs)) || (uses_rt && pending_write(rt));

    assign id_stall          = hazard;
    assign id_if_selpcsource = redirect && !hazard;
    assign id_if_selpctype   = pctype;
    assign id_if_pcimd2ext   = if_id_nextpc + {imm_ext[29:0], 2'b00};
    assign id_if_rega        = rs_val;
    assign id_if_pcindex     = {if_id_nextpc[31:28], if_id_instruc[25:0], 2'b00};

    idex_t idex_d;
    idex_t idex_q;

    assign idex_d = (issue && !hazard) ? dec : '0;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign id_ex_aluop    = idex_q.aluop;
    assign id_ex_alusrc   = idex_q.alusrc;
    assign id_ex_rega     = idex_q.rega;
    assign id_ex_regb     = idex_q.regb;
    assign id_ex_imedext  = idex_q.imedext;
    assign id_ex_regdest  = idex_q.regdest;
    assign id_ex_memread  = idex_q.memread;
    assign id_ex_memwrite = idex_q.memwrite;
    assign id_ex_regwrite = idex_q.regwrite;
    assign id_ex_memtoreg = idex_q.memtoreg;

endmodule

// File: doc/decode.md
# decode

Instruction-decode stage of the five-stage pipeline, directly downstream of instruction fetch. Consumes the fetched instruction word and its next-PC, reads the register bank, resolves branches and jumps in this stage (one architectural delay slot, no flush), detects data hazards and stalls fetch, and registers decoded operands and control into the ID/EX pipeline register.

## Interface
Parameters:
- EXC_VECTOR, 32'h0000_0040: illegal-opcode target; documentation only, fixed by selpctype 2'b11.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- if_id_nextpc  in  32  address of the fetched instruction + 4
- if_id_instruc  in  32  fetched instruction word
- id_stall  out  1  hold fetch; combinational
- id_if_selpcsource  out  1  redirect PC; combinational
- id_if_selpctype  out  2  00 branch, 01 jr, 10 jump, 11 exception
- id_if_pcimd2ext  out  32  if_id_nextpc + (signext(imm16) << 2)
- id_if_rega  out  32  rs value, the jr target
- id_if_pcindex  out  32  {if_id_nextpc[31:28], instr[25:0], 2'b00}
- ex_id_regwrite, ex_id_dest  in  1, 5  pending write in EX
- mem_id_regwrite, mem_id_dest  in  1, 5  pending write in MEM
- wb_id_we, wb_id_dest, wb_id_data  in  1, 5, 32  register-bank write port
- id_ex_aluop  out  3  000 add, 001 sub, 010 and, 011 or, 100 slt
- id_ex_alusrc  out  1  1 selects id_ex_imedext
- id_ex_rega, id_ex_regb  out  32  rs and rt values
- id_ex_imedext  out  32  sign-extended imm16
- id_ex_regdest  out  5  destination register
- id_ex_memread, id_ex_memwrite, id_ex_regwrite, id_ex_memtoreg  out  1 each

## Operation
- Decoded set:
  - R-type (op 0): add 20, sub 22, and 24, or 25, slt 2A (dest rd); jr 08 (no write).
  - I-type: addi 08, lw 23, sw 2B (dest rt for addi and lw).
  - Branch/jump: beq 04, bne 05, j 02.
- Any other opcode or funct is illegal: selpcsource=1, selpctype=11, bubble into ID/EX.
- Instruction word 0 (sll r0 nop) decodes as a bubble.
- Sources: rs for every instruction except j; rt for R-type, sw, beq and bne. r0 never causes a hazard.
- Hazard: a source equals ex_id_dest with ex_id_regwrite, or equals mem_id_dest with mem_id_regwrite.
  - id_stall=1.
  - selpcsource forced 0.
  - Bubble written into ID/EX.
  - if_id_* are held by fetch and the instruction is re-decoded next cycle.
- Branch: beq redirects when rs==rt; bne when rs!=rt. The comparison uses register-bank read values, including the WB bypass.
- j: selpctype=10. jr: selpctype=01. Both redirect unconditionally when not stalled.
- Bubble: memread, memwrite and regwrite are 0; every other ID/EX field is 0.
- Register bank (reg_bank):
  - 32×32, two asynchronous reads, one write on the clock edge.
  - r0 reads 0 and ignores writes.
  - Read of wb_id_dest while wb_id_we=1 returns wb_id_data (write-through).
  - Reset clears all entries.

## Timing
- id_stall and the id_if_* outputs are combinational from if_id_* and the hazard inputs. Fetch samples them on the same edge.
- ID/EX is updated every rising edge with either the decoded instruction or a bubble. Latency is 1 cycle.
- Reset (asynchronous): all id_ex_* outputs and all bank entries go to 0. Combinational outputs then follow from the zero instruction: id_stall=0, selpcsource=0.
- Simultaneous WB write and read of the same register in the same cycle: the new value is used for both ID/EX and the branch compare.
- Stall and illegal opcode in the same cycle: the stall wins and the redirect is suppressed.
- Reset deasserted mid-stream: the first decoded word is whatever fetch presents. There is no extra startup state.
- Arithmetic: all PC math is 32-bit modulo 2^32. imm16 is sign-extended before the shift.

## Structure
- Shared package decode_pkg:
  - opcode and funct localparams
  - aluop encodings
  - selpctype encodings (PCSRC_BRANCH, PCSRC_JR, PCSRC_JUMP, PCSRC_EXC)
- Sub-module reg_bank: register file with the write-through bypass.
- Decode, hazard and branch logic, plus the ID/EX register, live in decode.

## Test plan
- Reset mid-run with id_ex_regwrite=1 → all id_ex_* are 0 immediately, id_stall=0; after release, r5 reads 0.
- WB writes r3=0x1234 while decoding add r4,r3,r3 → id_ex_rega=id_ex_regb=0x1234, regdest=4, aluop=000, regwrite=1.
- beq r1,r2,+3 with r1=r2=7, nextpc=0x100 → selpcsource=1, selpctype=00, pcimd2ext=0x10C; with r2=8 → selpcsource=0.
- lw r2 in EX (ex_id_dest=2) and decoding sub r6,r2,r1 → id_stall=1 and a bubble; after the dependency clears, sub issues exactly once.
- j 0x3FFFFFF with nextpc=0xA0000004 → pcindex=0xAFFFFFFC, selpctype=10; jr r31=0x200 → selpctype=01, rega=0x200.
- Opcode 0x3F → selpctype=11, bubble; the same word combined with a hazard → id_stall=1, selpcsource=0.
